fpu_result_collector: RTL and testbench

- Consumer end of the FPU execution-unit result interface.
- Each unit (compare, add, mul, div/sqrt, ...) pulses a single-cycle result with dest reg, fflags and an int-dest flag, and cannot be stalled.
- This block captures every pulse into a per-source 2-entry buffer and round-robin arbitrates them onto one writeback port with ready/valid.
- It drives a per-source stall back to issue logic and maintains accrued fflags.

---
 rtl/fpu_result_collector.sv | 148 ++++++++++++++
 tb/tb_fpu_result_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fpu_result_collector.sv
// FPU result collector: per-source 2-entry buffers that absorb unstallable result
// pulses, merged round-robin onto one ready/valid writeback port with accrued fflags.

module fpu_result_collector_buf #(
  parameter int EW = 75
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic [EW-1:0] head,
  output logic          nonempty,
  output logic          overflow
);
  logic [EW-1:0] e0, e1;
  logic [1:0]    cnt;

  assign head     = e0;
  assign nonempty = (cnt != 2'd0);
  // A pop in the same cycle frees a slot, so only an unpopped full buffer drops.
  assign overflow = push && !pop && (cnt == 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: if (cnt != 2'd2) begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module fpu_result_collector #(
  parameter int N_SRC      = 4,
  parameter int FP_WIDTH_D = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_SRC-1:0]              i_src_valid,
  input  logic [N_SRC*FP_WIDTH_D-1:0]   i_src_result,
  input  logic [N_SRC*5-1:0]            i_src_dest,
  input  logic [N_SRC-1:0]              i_src_to_int,
  input  logic [N_SRC*5-1:0]            i_src_flags,
  output logic [N_SRC-1:0]              o_src_stall,
  output logic                          o_wb_valid,
  input  logic                          i_wb_ready,
  output logic [FP_WIDTH_D-1:0]         o_wb_data,
  output logic [4:0]                    o_wb_dest,
  output logic                          o_wb_to_int,
  output logic [$clog2(N_SRC)-1:0]      o_wb_src,
  output logic [4:0]                    o_wb_flags,
  input  logic                          i_fflags_clr,
  output logic [4:0]                    o_fflags_accrued,
  output logic                          o_overflow
);
  localparam int SW = $clog2(N_SRC);
  localparam int EW = FP_WIDTH_D + 11;

  logic [N_SRC-1:0][EW-1:0] din, head;
  logic [N_SRC-1:0]         nonempty, pop, ovf_p;
  logic [SW-1:0]            ptr, grant;
  logic [EW-1:0]            sel;
  logic                     xfer;
  logic [4:0]               accrued;
  logic                     ovf;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign din[k] = {i_src_result[k*FP_WIDTH_D +: FP_WIDTH_D], i_src_dest[k*5 +: 5],
                     i_src_to_int[k], i_src_flags[k*5 +: 5]};
    assign pop[k] = xfer && (grant == SW'(k));
    fpu_result_collector_buf #(.EW(EW)) u_buf (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .push     (i_src_valid[k]),
      .pop      (pop[k]),
      .din      (din[k]),
      .head     (head[k]),
      .nonempty (nonempty[k]),
      .overflow (ovf_p[k])
    );
  end

  // First non-empty source at or above the pointer, wrapping modulo N_SRC.
  always_comb begin : arb
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  assign o_wb_valid  = |nonempty;
  assign xfer        = o_wb_valid && i_wb_ready;
  assign sel         = head[grant];
  assign o_wb_data   = o_wb_valid ? sel[EW-1 -: FP_WIDTH_D] : '0;
  assign o_wb_dest   = o_wb_valid ? sel[10:6] : 5'd0;
  assign o_wb_to_int = o_wb_valid && sel[5];
  assign o_wb_flags  = o_wb_valid ? sel[4:0] : 5'd0;
  assign o_wb_src    = o_wb_valid ? grant : '0;
  assign o_src_stall = nonempty;
  assign o_fflags_accrued = accrued;
  assign o_overflow       = ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr     <= '0;
      accrued <= 5'd0;
      ovf     <= 1'b0;
    end else begin
      ovf <= ovf | (|ovf_p);
      if (xfer) begin
        ptr     <= (grant == SW'(N_SRC-1)) ? '0 : grant + 1'b1;
        // Flags of the retiring beat survive a same-cycle clear.
        accrued <= (i_fflags_clr ? 5'd0 : accrued) | o_wb_flags;
      end else if (i_fflags_clr) begin
        accrued <= 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed table-driven bench for fpu_result_collector (N_SRC=4, 64-bit results).
module tb_fpu_result_collector;
  localparam int N = 4;
  localparam int W = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_valid;
  logic [N*W-1:0]  src_result;
  logic [N*5-1:0]  src_dest;
  logic [N-1:0]    src_to_int;
  logic [N*5-1:0]  src_flags;
  logic [N-1:0]    src_stall;
  logic            wb_valid, wb_ready, wb_to_int, fflags_clr, overflow;
  logic [W-1:0]    wb_data;
  logic [4:0]      wb_dest, wb_flags, fflags_accrued;
  logic [1:0]      wb_src;

  int checks = 0;
  int failures = 0;

  fpu_result_collector #(.N_SRC(N), .FP_WIDTH_D(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_src_valid(src_valid), .i_src_result(src_result),
    .i_src_dest(src_dest), .i_src_to_int(src_to_int), .i_src_flags(src_flags),
    .o_src_stall(src_stall), .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
    .o_wb_data(wb_data), .o_wb_dest(wb_dest), .o_wb_to_int(wb_to_int),
    .o_wb_src(wb_src), .o_wb_flags(wb_flags), .i_fflags_clr(fflags_clr),
    .o_fflags_accrued(fflags_accrued), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic [4:0] dbase;
    logic       rdy, clr, rst;
    logic       ev;
    logic [1:0] esrc;
    logic [4:0] edest;
    logic [3:0] estall;
    logic [4:0] eacc;
    logic       eovf;
    logic [4:0] efl;
  } vec_t;

  function automatic logic [63:0] mkres(input logic [4:0] d);
    return {32'hFFFF_FFFF, 32'h3F80_0000 | {27'd0, d}};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [4:0] dbase,
      input logic rdy, input logic clr, input logic r, input logic ev,
      input logic [1:0] esrc, input logic [4:0] edest, input logic [3:0] estall,
      input logic [4:0] eacc, input logic eovf, input logic [4:0] efl);
    vec_t t;
    t.v = v; t.dbase = dbase; t.rdy = rdy; t.clr = clr; t.rst = r; t.ev = ev;
    t.esrc = esrc; t.edest = edest; t.estall = estall; t.eacc = eacc;
    t.eovf = eovf; t.efl = efl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Source k gets dest dbase+k, flag bit k, to_int = k[0].
  task automatic set_in(input logic [3:0] v, input logic [4:0] dbase,
      input logic rdy, input logic clr, input logic r);
    logic [4:0] d;
    src_valid = v; wb_ready = rdy; fflags_clr = clr; rst = r;
    for (int k = 0; k < N; k++) begin
      d = dbase + 5'(k);
      src_dest[k*5 +: 5]   = d;
      src_result[k*W +: W] = mkres(d);
      src_flags[k*5 +: 5]  = 5'(1 << k);
      src_to_int[k]        = k[0];
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [1:0] es,
      input logic [4:0] ed, input logic [3:0] est, input logic [4:0] eacc,
      input logic eovf, input logic [4:0] efl);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(ev));
    chk({tag, ".src"},   64'(wb_src),   64'(es));
    chk({tag, ".dest"},  64'(wb_dest),  64'(ed));
    chk({tag, ".data"},  wb_data,       ev ? mkres(ed) : 64'd0);
    chk({tag, ".toint"}, 64'(wb_to_int), 64'(ev & es[0]));
    chk({tag, ".flags"}, 64'(wb_flags), 64'(efl));
    chk({tag, ".stall"}, 64'(src_stall), 64'(est));
    chk({tag, ".acc"},   64'(fflags_accrued), 64'(eacc));
    chk({tag, ".ovf"},   64'(overflow), 64'(eovf));
  endtask

  vec_t tv[29];

  initial begin
    // single pulse, reset, 4-way burst twice, 2-deep fill, overflow
    tv[0]  = mk(4'h1,  5, 1,0,0, 0,0, 0,4'h0,5'h00,0,5'h00);
    tv[1]  = mk(4'h0,  0, 1,0,0, 1,0, 5,4'h1,5'h00,0,5'h01);
    tv[2]  = mk(4'h0,  0, 1,0,0, 0,0, 0,4'h0,5'h01,0,5'h00);
    tv[3]  = mk(4'h0,  0, 1,0,1, 0,0, 0,4'h0,5'h01,0,5'h00);
    tv[4]  = mk(4'hF,  1, 1,0,0, 0,0, 0,4'h0,5'h00,0,5'h00);
    tv[5]  = mk(4'h0,  0, 1,0,0, 1,0, 1,4'hF,5'h00,0,5'h01);
    tv[6]  = mk(4'h0,  0, 1,0,0, 1,1, 2,4'hE,5'h01,0,5'h02);
    tv[7]  = mk(4'h0,  0, 1,0,0, 1,2, 3,4'hC,5'h03,0,5'h04);
    tv[8]  = mk(4'h0,  0, 1,0,0, 1,3, 4,4'h8,5'h07,0,5'h08);
    tv[9]  = mk(4'hF,  9, 1,0,0, 0,0, 0,4'h0,5'h0F,0,5'h00);
    tv[10] = mk(4'h0,  0, 1,0,0, 1,0, 9,4'hF,5'h0F,0,5'h01);
    tv[11] = mk(4'h0,  0, 1,0,0, 1,1,10,4'hE,5'h0F,0,5'h02);
    tv[12] = mk(4'h0,  0, 1,0,0, 1,2,11,4'hC,5'h0F,0,5'h04);
    tv[13] = mk(4'h0,  0, 1,0,0, 1,3,12,4'h8,5'h0F,0,5'h08);
    tv[14] = mk(4'h0,  0, 1,0,0, 0,0, 0,4'h0,5'h0F,0,5'h00);
    tv[15] = mk(4'h4, 20, 0,0,0, 0,0, 0,4'h0,5'h0F,0,5'h00);
    tv[16] = mk(4'h4, 21, 0,0,0, 1,2,22,4'h4,5'h0F,0,5'h04);
    tv[17] = mk(4'h0,  0, 0,0,0, 1,2,22,4'h4,5'h0F,0,5'h04);
    tv[18] = mk(4'h0,  0, 0,0,0, 1,2,22,4'h4,5'h0F,0,5'h04);
    tv[19] = mk(4'h0,  0, 1,0,0, 1,2,22,4'h4,5'h0F,0,5'h04);
    tv[20] = mk(4'h0,  0, 1,0,0, 1,2,23,4'h4,5'h0F,0,5'h04);
    tv[21] = mk(4'h0,  0, 1,0,0, 0,0, 0,4'h0,5'h0F,0,5'h00);
    tv[22] = mk(4'h2, 13, 0,0,0, 0,0, 0,4'h0,5'h0F,0,5'h00);
    tv[23] = mk(4'h2, 14, 0,0,0, 1,1,14,4'h2,5'h0F,0,5'h02);
    tv[24] = mk(4'h2, 15, 0,0,0, 1,1,14,4'h2,5'h0F,0,5'h02);
    tv[25] = mk(4'h0,  0, 0,0,0, 1,1,14,4'h2,5'h0F,1,5'h02);
    tv[26] = mk(4'h0,  0, 1,0,0, 1,1,14,4'h2,5'h0F,1,5'h02);
    tv[27] = mk(4'h0,  0, 1,0,0, 1,1,15,4'h2,5'h0F,1,5'h02);
    tv[28] = mk(4'h0,  0, 1,0,0, 0,0, 0,4'h0,5'h0F,1,5'h00);

    set_in(4'h0, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_in(4'h0, 0, 1'b0, 1'b0, 1'b0);
    #1 chk_state("reset", 0, 0, 0, 4'h0, 5'h00, 0, 5'h00);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      set_in(tv[i].v, tv[i].dbase, tv[i].rdy, tv[i].clr, tv[i].rst);
      #1 chk_state($sformatf("v%0d", i), tv[i].ev, tv[i].esrc, tv[i].edest,
                   tv[i].estall, tv[i].eacc, tv[i].eovf, tv[i].efl);
    end

    // Same-cycle clear and transfer: new flags survive.
    @(negedge clk); set_in(4'h0, 0, 1, 1, 0);
    @(negedge clk); set_in(4'h1, 0, 1, 0, 0); src_flags[4:0] = 5'h03;
    #1 chk("clr.acc", 64'(fflags_accrued), 64'h00);
    @(negedge clk); set_in(4'h0, 0, 1, 0, 0);
    #1 chk("clr.fl03", 64'(wb_flags), 64'h03);
    @(negedge clk); set_in(4'h8, 0, 1, 0, 0); src_flags[19:15] = 5'h10;
    #1 chk("clr.acc03", 64'(fflags_accrued), 64'h03);
    @(negedge clk); set_in(4'h0, 0, 1, 1, 0);
    #1 chk("clr.src3", 64'(wb_src), 64'd3);
    chk("clr.fl10", 64'(wb_flags), 64'h10);
    @(negedge clk); set_in(4'h0, 0, 1, 0, 0);
    #1 chk("clr.acc10", 64'(fflags_accrued), 64'h10);

    // Move pointer to 3, fill two buffers, reset: entries dropped, pointer back to 0.
    @(negedge clk); set_in(4'h4, 0, 1, 0, 0);
    @(negedge clk); set_in(4'h0, 0, 1, 0, 0);
    #1 chk("rst.pre_src", 64'(wb_src), 64'd2);
    @(negedge clk); set_in(4'h5, 0, 0, 0, 0);
    @(negedge clk); set_in(4'h0, 0, 0, 0, 1);
    #1 chk("rst.pre_stall", 64'(src_stall), 64'h5);
    @(negedge clk); set_in(4'h9, 0, 0, 0, 0);
    #1 chk_state("rst.post", 0, 0, 0, 4'h0, 5'h00, 0, 5'h00);
    @(negedge clk); set_in(4'h0, 0, 0, 0, 0);
    #1 chk("rst.ptr0", 64'(wb_src), 64'd0);
    chk("rst.stall", 64'(src_stall), 64'h9);
    @(negedge clk); set_in(4'h0, 0, 1, 0, 0);
    @(negedge clk);
    #1 chk("rst.next_src", 64'(wb_src), 64'd3);
    @(negedge clk);
    #1 chk("rst.drained", 64'(wb_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
